tdc_raw_encoder: RTL and testbench
==================================

# tdc_raw_encoder

Parametrised encoder that sits directly behind the TDC delay line. It takes one TOA and one TOT raw thermometer-code snapshot plus their coarse ripple-counter values and applies bubble correction and a thermometer-validity check. It converts each hit to binary TOA/TOT codes through a 3-stage pipeline and presents the result on a single-entry valid/ready output register. Tap counts, counter width and code widths are generics, so the same block serves both the current 63/21-tap line and longer or shorter lines.

## Interface
Parameters:
- TOA_TAPS, 63, TOA delay-line taps.
- TOT_TAPS, 21, TOT delay-line taps.
- CNT_W, 3, coarse counter width (both TOA and TOT).
- TOA_W, 10, TOACode width; must be ≥ ceil(log2((2^CNT_W)·TOA_TAPS+1)).
- TOT_W, 9, TOTCode width; same rule with TOT_TAPS.
- DROP_W, 8, drop-counter width.

Ports:
- Clk  in  1  single clock; all logic is on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- RawValid  in  1  one-cycle strobe: the raw inputs are valid this cycle.
- TOARaw  in  TOA_TAPS  TOA thermometer snapshot; bit 0 = first tap.
- TOTRaw  in  TOT_TAPS  TOT thermometer snapshot.
- TOACnt  in  CNT_W  TOA coarse count.
- TOTCnt  in  CNT_W  TOT coarse count.
- CalMode  in  1  1 = calibration: ignore the coarse counts and output the fine code only.
- DoutReady  in  1  consumer accepts the output word.
- DoutValid  out  1  output word valid.
- TOACode  out  TOA_W  encoded TOA.
- TOTCode  out  TOT_W  encoded TOT.
- ErrFlag  out  1  TOA or TOT vector was not a thermometer code after correction.
- DropCnt  out  DROP_W  saturating count of words lost to backpressure.

## Operation
- **S1:** on RawValid, register TOARaw, TOTRaw, TOACnt, TOTCnt and CalMode, and set v1. When RawValid is low, v1 = 0.
- **S2:** bubble-correct each vector with b[i] = majority(r[i-1], r[i], r[i+1]). Boundary values are r[-1] = 1 and r[TAPS] = 0.
  - Thermometer check: the corrected vector is valid only if it is of the form 0…01…1. This includes all-zero and all-one vectors.
  - Register the corrected vectors and err = ~validTOA | ~validTOT. Carry v1 forward as v2.
- **S3:** fine = popcount of the corrected vector (range 0..TAPS).
  - Normal mode: TOACode = TOACnt·TOA_TAPS + fineTOA, and TOTCode = TOTCnt·TOT_TAPS + fineTOT.
  - Calibration mode: each code is its fine value, zero-extended.
  - If a result does not fit its code width, saturate it to all ones.
  - Result and v3 are registered.
- **Output register:**
  - It loads the S3 result when v3 = 1 and the register is free. The register is free when DoutValid = 0 or DoutReady = 1.
  - If v3 = 1 and DoutValid = 1 and DoutReady = 0, the new word is dropped and DropCnt increments, saturating at all ones. The held word stays unchanged.
  - If DoutValid = 1, DoutReady = 1 and v3 = 0, DoutValid clears.
- The pipeline never stalls. Backpressure only drops words; it never corrupts a held word.
- **Reset mid-operation:** all pipeline valids clear immediately, in-flight hits are discarded and DropCnt clears.

## Timing
- Reset values: DoutValid = 0, TOACode = 0, TOTCode = 0, ErrFlag = 0, DropCnt = 0, and all internal valids = 0.
- Latency: RawValid sampled at edge N gives DoutValid = 1 after edge N+3, provided the output register is free.
- Throughput is one hit per clock while DoutReady = 1.
- TOACode, TOTCode and ErrFlag are stable whenever DoutValid = 1 and DoutReady = 0.
- The handshake transfer happens on the edge where DoutValid & DoutReady are both 1.
- A simultaneous transfer and new arrival on the same edge loads the new word with no gap.
- CalMode is sampled per hit at S1. Changing it mid-stream affects only later hits.

## Structure
- Shared package `tdc_pkg` holds:
  - default tap counts and widths;
  - a `ceil_log2` function;
  - a combined-code width check, exposed as an elaboration-time assertion helper.
- One sub-module is natural: `tdc_therm_decode` (parameter TAPS). It implements bubble correction, the thermometer check and popcount, and is instantiated twice (TOA and TOT), with the S2/S3 registers inside.
- The top level holds S1, the code combine step, the output register and DropCnt.

## Test plan
- **Basic encode:** TOARaw with ones in bits 0..19, TOACnt = 2, TOTRaw with ones in bits 0..4, TOTCnt = 1, CalMode = 0, DoutReady = 1. Required: after 3 cycles TOACode = 146, TOTCode = 26, ErrFlag = 0, DoutValid high for one cycle.
- **Bubble correction:** same TOA vector but bit 7 cleared. Required: TOACode = 146, ErrFlag = 0.
- **Invalid thermometer:** TOA ones in bits 0..9 and 30..39, TOACnt = 2. Required: ErrFlag = 1, TOACode = 146 (popcount 20).
- **Calibration mode:** CalMode = 1, TOA all 63 ones, TOACnt = 7. Required: TOACode = 63, TOTCode = fine only.
- **Backpressure:** DoutReady = 0, RawValid on 3 consecutive cycles. Required: the first word is held unchanged and DropCnt = 2. Raising DoutReady then gives exactly one transfer, after which DoutValid = 0.
- **Reset mid-flight:** assert Reset one cycle after RawValid. Required: no DoutValid appears afterwards and all outputs are 0; a hit after reset is released encodes normally with 3-cycle latency.

Source files
------------

// File: rtl/tdc_pkg.sv
// tdc_pkg
//   Shared definitions for the TDC raw encoder:
//   - default tap counts and code widths of the current delay line
//   - ceil_log2: constant function used to size counters and codes
//   - code_width_ok: elaboration-time check that a combined
//     coarse*TAPS+fine code fits its configured width
package tdc_pkg;

    localparam int TOA_TAPS_DEF = 63;
    localparam int TOT_TAPS_DEF = 21;
    localparam int CNT_W_DEF    = 3;
    localparam int TOA_W_DEF    = 10;
    localparam int TOT_W_DEF    = 9;
    localparam int DROP_W_DEF   = 8;

    // Smallest w such that 2**w >= value.
    function automatic int ceil_log2(input int value);
        int          width;
        longint      span;
        width = 0;
        span  = 1;
        while (span < longint'(value)) begin
            span  = span << 1;
            width = width + 1;
        end
        return width;
    endfunction

    // True when a code of codeW bits can hold every value 0..(2**cntW)*taps.
    function automatic bit code_width_ok(input int cntW, input int taps, input int codeW);
        return codeW >= ceil_log2((1 << cntW) * taps + 1);
    endfunction

endpackage

// File: rtl/tdc_therm_decode.sv
// tdc_therm_decode
//   Decodes one registered thermometer snapshot into a fine count.
//   S2 stage: bubble correction + thermometer-validity check (registered).
//   S3 stage: popcount of the corrected vector (registered).
//   Data registers run every cycle; hit validity is tracked by the parent.
// Ports:
//   clk_i      rising-edge clock
//   rst_i      asynchronous active-high reset
//   raw_i      S1-registered snapshot, bit 0 = first tap
//   fine_o     S3 fine count (0..TAPS)
//   thermOk_o  S3 flag: corrected vector was a clean thermometer code
module tdc_therm_decode
    import tdc_pkg::*;
#(
    parameter int TAPS   = TOA_TAPS_DEF,
    parameter int FINE_W = ceil_log2(TAPS + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [TAPS-1:0]   raw_i,
    output logic [FINE_W-1:0] fine_o,
    output logic              thermOk_o
);

    logic [TAPS+1:0]   rawExt;
    logic [TAPS-1:0]   corr_d;
    logic [TAPS-1:0]   corr_q;
    logic              ok_d;
    logic              ok2_q;
    logic [FINE_W-1:0] fine_d;
    logic [FINE_W-1:0] fine_q;
    logic              ok3_q;

    // Padding models a tap before the line that has always fired (1) and a
    // tap past the end that never fires (0), so edge taps correct sensibly.
    assign rawExt = {1'b0, raw_i, 1'b1};

    // 3-input majority; rawExt[i+1] is tap i, rawExt[i] and rawExt[i+2] its neighbours.
    always_comb begin
        corr_d = '0;
        for (int i = 0; i < TAPS; i++) begin
            corr_d[i] = (rawExt[i] & rawExt[i+1]) | (rawExt[i] & rawExt[i+2]) |
                        (rawExt[i+1] & rawExt[i+2]);
        end
    end

    // A one above a zero means the vector is not of the form 0..01..1.
    always_comb begin
        ok_d = 1'b1;
        for (int i = 1; i < TAPS; i++) begin
            if (corr_d[i] && !corr_d[i-1]) begin
                ok_d = 1'b0;
            end
        end
    end

    always_comb begin
        fine_d = '0;
        for (int i = 0; i < TAPS; i++) begin
            fine_d = fine_d + FINE_W'(corr_q[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            corr_q <= '0;
            ok2_q  <= 1'b0;
            fine_q <= '0;
            ok3_q  <= 1'b0;
        end else begin
            corr_q <= corr_d;
            ok2_q  <= ok_d;
            fine_q <= fine_d;
            ok3_q  <= ok2_q;
        end
    end

    assign fine_o    = fine_q;
    assign thermOk_o = ok3_q;

endmodule

// File: rtl/tdc_raw_encoder.sv
// tdc_raw_encoder
//   Converts TOA/TOT thermometer snapshots plus coarse counts into binary
//   codes through a 3-stage pipeline and a single-entry valid/ready output
//   register. The pipeline never stalls: a word arriving while the output
//   is held is dropped and counted in DropCnt.
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   RawValid            one-cycle strobe qualifying TOARaw/TOTRaw/TOACnt/TOTCnt/CalMode
//   TOARaw, TOTRaw      thermometer snapshots, bit 0 = first tap
//   TOACnt, TOTCnt      coarse ripple-counter values
//   CalMode             1 = output fine codes only (sampled per hit)
//   DoutReady           consumer accepts the output word
//   DoutValid           output word valid
//   TOACode, TOTCode    encoded codes, saturated to all ones on overflow
//   ErrFlag             TOA or TOT was not a thermometer code after correction
//   DropCnt             saturating count of words lost to backpressure
module tdc_raw_encoder
    import tdc_pkg::*;
#(
    parameter int TOA_TAPS = TOA_TAPS_DEF,
    parameter int TOT_TAPS = TOT_TAPS_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int TOA_W    = TOA_W_DEF,
    parameter int TOT_W    = TOT_W_DEF,
    parameter int DROP_W   = DROP_W_DEF
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                RawValid,
    input  logic [TOA_TAPS-1:0] TOARaw,
    input  logic [TOT_TAPS-1:0] TOTRaw,
    input  logic [CNT_W-1:0]    TOACnt,
    input  logic [CNT_W-1:0]    TOTCnt,
    input  logic                CalMode,
    input  logic                DoutReady,
    output logic                DoutValid,
    output logic [TOA_W-1:0]    TOACode,
    output logic [TOT_W-1:0]    TOTCode,
    output logic                ErrFlag,
    output logic [DROP_W-1:0]   DropCnt
);

    localparam int TOA_FW = ceil_log2(TOA_TAPS + 1);
    localparam int TOT_FW = ceil_log2(TOT_TAPS + 1);
    localparam logic [31:0] TOA_MAX = 32'((64'd1 << TOA_W) - 64'd1);
    localparam logic [31:0] TOT_MAX = 32'((64'd1 << TOT_W) - 64'd1);

    if (!code_width_ok(CNT_W, TOA_TAPS, TOA_W)) begin : gToaWidthCheck
        $error("tdc_raw_encoder: TOA_W too narrow for CNT_W and TOA_TAPS");
    end
    if (!code_width_ok(CNT_W, TOT_TAPS, TOT_W)) begin : gTotWidthCheck
        $error("tdc_raw_encoder: TOT_W too narrow for CNT_W and TOT_TAPS");
    end

    logic [TOA_TAPS-1:0] toaRaw_q;
    logic [TOT_TAPS-1:0] totRaw_q;
    logic [CNT_W-1:0]    toaCnt1_q, toaCnt2_q, toaCnt3_q;
    logic [CNT_W-1:0]    totCnt1_q, totCnt2_q, totCnt3_q;
    logic                cal1_q, cal2_q, cal3_q;
    logic                v1_q, v2_q, v3_q;

    logic [TOA_FW-1:0]   toaFine;
    logic [TOT_FW-1:0]   totFine;
    logic                toaOk, totOk;

    logic [31:0]         toaSum, totSum;
    logic [TOA_W-1:0]    toaNew;
    logic [TOT_W-1:0]    totNew;
    logic                outFree;

    logic                doutValid_d, doutValid_q;
    logic [TOA_W-1:0]    toaCode_d, toaCode_q;
    logic [TOT_W-1:0]    totCode_d, totCode_q;
    logic                err_d, err_q;
    logic [DROP_W-1:0]   dropCnt_d, dropCnt_q;

    // S1 capture plus the side-band (coarse counts, mode, valid) that must
    // travel alongside the fine decode to reach the combine step aligned.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            toaRaw_q  <= '0;
            totRaw_q  <= '0;
            toaCnt1_q <= '0;
            totCnt1_q <= '0;
            cal1_q    <= 1'b0;
            toaCnt2_q <= '0;
            totCnt2_q <= '0;
            cal2_q    <= 1'b0;
            toaCnt3_q <= '0;
            totCnt3_q <= '0;
            cal3_q    <= 1'b0;
        end else begin
            v1_q <= RawValid;
            if (RawValid) begin
                toaRaw_q  <= TOARaw;
                totRaw_q  <= TOTRaw;
                toaCnt1_q <= TOACnt;
                totCnt1_q <= TOTCnt;
                cal1_q    <= CalMode;
            end
            v2_q      <= v1_q;
            toaCnt2_q <= toaCnt1_q;
            totCnt2_q <= totCnt1_q;
            cal2_q    <= cal1_q;
            v3_q      <= v2_q;
            toaCnt3_q <= toaCnt2_q;
            totCnt3_q <= totCnt2_q;
            cal3_q    <= cal2_q;
        end
    end

    tdc_therm_decode #(
        .TAPS   (TOA_TAPS),
        .FINE_W (TOA_FW)
    ) uToaDecode (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .raw_i     (toaRaw_q),
        .fine_o    (toaFine),
        .thermOk_o (toaOk)
    );

    tdc_therm_decode #(
        .TAPS   (TOT_TAPS),
        .FINE_W (TOT_FW)
    ) uTotDecode (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .raw_i     (totRaw_q),
        .fine_o    (totFine),
        .thermOk_o (totOk)
    );

    // Combine in 32 bits so overflow is detectable before narrowing.
    always_comb begin
        toaSum = cal3_q ? 32'(toaFine) : 32'(toaCnt3_q) * 32'(TOA_TAPS) + 32'(toaFine);
        totSum = cal3_q ? 32'(totFine) : 32'(totCnt3_q) * 32'(TOT_TAPS) + 32'(totFine);
        toaNew = (toaSum > TOA_MAX) ? '1 : toaSum[TOA_W-1:0];
        totNew = (totSum > TOT_MAX) ? '1 : totSum[TOT_W-1:0];
    end

    assign outFree = !doutValid_q || DoutReady;

    // Output register: a free register (empty or being drained) loads the
    // new word with no gap; a held word is never overwritten, the newcomer
    // is dropped instead.
    always_comb begin
        doutValid_d = doutValid_q;
        toaCode_d   = toaCode_q;
        totCode_d   = totCode_q;
        err_d       = err_q;
        dropCnt_d   = dropCnt_q;
        if (v3_q) begin
            if (outFree) begin
                doutValid_d = 1'b1;
                toaCode_d   = toaNew;
                totCode_d   = totNew;
                err_d       = !toaOk || !totOk;
            end else if (dropCnt_q != {DROP_W{1'b1}}) begin
                dropCnt_d = dropCnt_q + 1'b1;
            end
        end else if (DoutReady) begin
            doutValid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            doutValid_q <= 1'b0;
            toaCode_q   <= '0;
            totCode_q   <= '0;
            err_q       <= 1'b0;
            dropCnt_q   <= '0;
        end else begin
            doutValid_q <= doutValid_d;
            toaCode_q   <= toaCode_d;
            totCode_q   <= totCode_d;
            err_q       <= err_d;
            dropCnt_q   <= dropCnt_d;
        end
    end

    assign DoutValid = doutValid_q;
    assign TOACode   = toaCode_q;
    assign TOTCode   = totCode_q;
    assign ErrFlag   = err_q;
    assign DropCnt   = dropCnt_q;

endmodule

// File: tb/tb_tdc_raw_encoder.sv
// tb_tdc_raw_encoder
//   Directed scenarios followed by a randomized run. Every cycle the DUT
//   outputs are compared with a reference model that works on whole hits:
//   each hit is encoded with integer arithmetic, delayed three cycles, then
//   passed through a behavioural single-entry output register.
module tb_tdc_raw_encoder;

    localparam int TOA_TAPS = 63;
    localparam int TOT_TAPS = 21;
    localparam int TOA_W    = 10;
    localparam int TOT_W    = 9;
    localparam int DROP_MAX = 255;

    logic        Clk;
    logic        Reset;
    logic        RawValid;
    logic [62:0] TOARaw;
    logic [20:0] TOTRaw;
    logic [2:0]  TOACnt;
    logic [2:0]  TOTCnt;
    logic        CalMode;
    logic        DoutReady;
    logic        DoutValid;
    logic [9:0]  TOACode;
    logic [8:0]  TOTCode;
    logic        ErrFlag;
    logic [7:0]  DropCnt;

    tdc_raw_encoder dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .RawValid  (RawValid),
        .TOARaw    (TOARaw),
        .TOTRaw    (TOTRaw),
        .TOACnt    (TOACnt),
        .TOTCnt    (TOTCnt),
        .CalMode   (CalMode),
        .DoutReady (DoutReady),
        .DoutValid (DoutValid),
        .TOACode   (TOACode),
        .TOTCode   (TOTCode),
        .ErrFlag   (ErrFlag),
        .DropCnt   (DropCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        bit valid;
        int toa;
        int tot;
        bit err;
    } word_t;

    word_t pipe [3];
    bit    mValid;
    int    mToa;
    int    mTot;
    bit    mErr;
    int    mDrop;
    int    checks = 0;
    int    errors = 0;

    function automatic bit [127:0] therm(input int k);
        return (128'd1 << k) - 128'd1;
    endfunction

    // Majority-vote correction, then validity = "value is 2**n - 1".
    function automatic int refFine(input bit [127:0] raw, input int taps, output bit ok);
        bit [127:0] corr;
        int         fine;
        int         below;
        int         above;
        corr = '0;
        for (int i = 0; i < taps; i++) begin
            below   = (i == 0) ? 1 : int'(raw[i-1]);
            above   = (i == taps - 1) ? 0 : int'(raw[i+1]);
            corr[i] = (below + int'(raw[i]) + above) >= 2;
        end
        fine = $countones(corr);
        ok   = (corr == therm(fine));
        return fine;
    endfunction

    function automatic int refCode(input int cnt, input int fine, input int taps,
                                   input bit cal, input int width);
        int value;
        int maxv;
        value = cal ? fine : cnt * taps + fine;
        maxv  = (1 << width) - 1;
        return (value > maxv) ? maxv : value;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            pipe[i].valid = 1'b0;
            pipe[i].toa   = 0;
            pipe[i].tot   = 0;
            pipe[i].err   = 1'b0;
        end
        mValid = 1'b0;
        mToa   = 0;
        mTot   = 0;
        mErr   = 1'b0;
        mDrop  = 0;
    endtask

    // Advance the model by one rising edge using the inputs presented to it.
    task automatic modelEdge();
        word_t w;
        bit    okA;
        bit    okB;
        int    fA;
        int    fB;
        if (Reset) begin
            modelReset();
            return;
        end
        if (pipe[2].valid) begin
            if (!mValid || DoutReady) begin
                mValid = 1'b1;
                mToa   = pipe[2].toa;
                mTot   = pipe[2].tot;
                mErr   = pipe[2].err;
            end else if (mDrop < DROP_MAX) begin
                mDrop = mDrop + 1;
            end
        end else if (DoutReady) begin
            mValid = 1'b0;
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        fA      = refFine(128'(TOARaw), TOA_TAPS, okA);
        fB      = refFine(128'(TOTRaw), TOT_TAPS, okB);
        w.valid = RawValid;
        w.toa   = refCode(int'(TOACnt), fA, TOA_TAPS, CalMode, TOA_W);
        w.tot   = refCode(int'(TOTCnt), fB, TOT_TAPS, CalMode, TOT_W);
        w.err   = !(okA && okB);
        pipe[0] = w;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("model.DoutValid", 32'(DoutValid), 32'(mValid));
        checkOutput("model.TOACode", 32'(TOACode), 32'(mToa));
        checkOutput("model.TOTCode", 32'(TOTCode), 32'(mTot));
        checkOutput("model.ErrFlag", 32'(ErrFlag), 32'(mErr));
        checkOutput("model.DropCnt", 32'(DropCnt), 32'(mDrop));
    endtask

    task automatic applyStimulus(input bit rv, input logic [62:0] toa, input logic [20:0] tot,
                                 input int tc, input int ti, input bit cal, input bit rdy);
        RawValid  = rv;
        TOARaw    = toa;
        TOTRaw    = tot;
        TOACnt    = 3'(tc);
        TOTCnt    = 3'(ti);
        CalMode   = cal;
        DoutReady = rdy;
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(1'b0, '0, '0, 0, 0, 1'b0, rdy);
    endtask

    task automatic tick();
        @(posedge Clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    // Called #1 after an edge; the reset spans exactly one rising edge.
    task automatic pulseReset();
        Reset = 1'b1;
        #2;
        modelReset();
        checkAll();
        tick();
        Reset = 1'b0;
    endtask

    function automatic bit [127:0] randVec(input int taps);
        bit [127:0] v;
        int         mode;
        v    = therm($urandom_range(0, taps));
        mode = $urandom_range(0, 3);
        if (mode == 0) begin
            v = v ^ (128'd1 << $urandom_range(0, taps - 1));
        end else if (mode == 1) begin
            v = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        return v;
    endfunction

    logic [62:0] vec;

    initial begin
        Reset = 1'b1;
        idle(1'b1);
        modelReset();
        #3;
        checkAll();
        tick();
        Reset = 1'b0;
        tick();

        $display("[TB] basic encode");
        applyStimulus(1'b1, 63'(therm(20)), 21'(therm(5)), 2, 1, 1'b0, 1'b1);
        tick();
        idle(1'b1);
        tick();
        tick();
        checkOutput("basic.notEarly", 32'(DoutValid), 32'd0);
        tick();
        checkOutput("basic.DoutValid", 32'(DoutValid), 32'd1);
        checkOutput("basic.TOACode", 32'(TOACode), 32'd146);
        checkOutput("basic.TOTCode", 32'(TOTCode), 32'd26);
        checkOutput("basic.ErrFlag", 32'(ErrFlag), 32'd0);
        tick();
        checkOutput("basic.onePulse", 32'(DoutValid), 32'd0);

        $display("[TB] bubble correction");
        vec    = 63'(therm(20));
        vec[7] = 1'b0;
        applyStimulus(1'b1, vec, 21'(therm(5)), 2, 1, 1'b0, 1'b1);
        tick();
        idle(1'b1);
        tick();
        tick();
        tick();
        checkOutput("bubble.TOACode", 32'(TOACode), 32'd146);
        checkOutput("bubble.ErrFlag", 32'(ErrFlag), 32'd0);
        tick();

        $display("[TB] invalid thermometer");
        vec = 63'(therm(10)) | (63'(therm(10)) << 30);
        applyStimulus(1'b1, vec, 21'(therm(5)), 2, 1, 1'b0, 1'b1);
        tick();
        idle(1'b1);
        tick();
        tick();
        tick();
        checkOutput("invalid.TOACode", 32'(TOACode), 32'd146);
        checkOutput("invalid.ErrFlag", 32'(ErrFlag), 32'd1);
        tick();

        $display("[TB] calibration mode");
        applyStimulus(1'b1, '1, 21'(therm(5)), 7, 1, 1'b1, 1'b1);
        tick();
        idle(1'b1);
        tick();
        tick();
        tick();
        checkOutput("cal.TOACode", 32'(TOACode), 32'd63);
        checkOutput("cal.TOTCode", 32'(TOTCode), 32'd5);
        checkOutput("cal.ErrFlag", 32'(ErrFlag), 32'd0);
        tick();

        $display("[TB] backpressure");
        applyStimulus(1'b1, 63'(therm(3)), 21'(therm(2)), 0, 0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 63'(therm(30)), 21'(therm(9)), 4, 3, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 63'(therm(50)), 21'(therm(15)), 5, 6, 1'b0, 1'b0);
        tick();
        idle(1'b0);
        tick();
        tick();
        tick();
        checkOutput("bp.held", 32'(DoutValid), 32'd1);
        checkOutput("bp.TOACode", 32'(TOACode), 32'd3);
        checkOutput("bp.TOTCode", 32'(TOTCode), 32'd2);
        checkOutput("bp.DropCnt", 32'(DropCnt), 32'd2);
        idle(1'b1);
        tick();
        checkOutput("bp.drained", 32'(DoutValid), 32'd0);
        tick();
        checkOutput("bp.noSecond", 32'(DoutValid), 32'd0);

        $display("[TB] reset mid-flight");
        applyStimulus(1'b1, 63'(therm(20)), 21'(therm(5)), 2, 1, 1'b0, 1'b1);
        tick();
        idle(1'b1);
        tick();
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        checkOutput("rst.DoutValid", 32'(DoutValid), 32'd0);
        checkOutput("rst.TOACode", 32'(TOACode), 32'd0);
        checkOutput("rst.TOTCode", 32'(TOTCode), 32'd0);
        checkOutput("rst.DropCnt", 32'(DropCnt), 32'd0);
        applyStimulus(1'b1, 63'(therm(20)), 21'(therm(5)), 2, 1, 1'b0, 1'b1);
        tick();
        idle(1'b1);
        tick();
        tick();
        checkOutput("rst.latency2", 32'(DoutValid), 32'd0);
        tick();
        checkOutput("rst.latency3", 32'(DoutValid), 32'd1);
        checkOutput("rst.TOACodeAfter", 32'(TOACode), 32'd146);
        tick();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 63'(randVec(TOA_TAPS)),
                          21'(randVec(TOT_TAPS)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 9) < 7));
            tick();
        end
        idle(1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
